muldiv_unit: RTL and testbench

- Parametrised, iterative RV32M multiply/divide unit; companion to the single-cycle ALU in the execute stage.
- Accepts one operation per request over a valid/ready handshake and computes one bit per cycle.
- Returns the result over a valid/ready handshake.
- The execute stage stalls on in_ready/out_valid and uses flush to kill the unit on a pipeline redirect.

---
 rtl/muldiv_unit_if.sv | 24 ++
 rtl/muldiv_unit.sv | 121 ++++++++++++
 tb/tb_muldiv_unit.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response handshake bundle between the execute stage and muldiv_unit.
// The execute stage is the master; the multiply/divide unit is the slave.
interface muldiv_unit_if #(
    parameter int N_BITS = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op;
    logic [N_BITS-1:0] in0;
    logic [N_BITS-1:0] in1;
    logic              out_valid;
    logic              out_ready;
    logic [N_BITS-1:0] out;

    modport master (
        output in_valid, op, in0, in1, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, op, in0, in1, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide, one bit per cycle: N_BITS+1 cycles, 1 cycle for div-by-zero/overflow.
// Holds the result in DONE until out_ready; accepts a new request only from IDLE; flush drops everything.
module muldiv_unit #(
    parameter int N_BITS = 32,
    parameter int CNT_W  = $clog2(N_BITS)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [N_BITS-1:0] MIN_NEG  = {1'b1, {(N_BITS-1){1'b0}}};
    localparam logic [N_BITS-1:0] ALL_ONES = '1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic [N_BITS-1:0]   opnd_q, opnd_d;
    logic [2*N_BITS-1:0] acc_q, acc_d;
    logic [N_BITS-1:0]   out_q, out_d;

    logic                accept, is_div, s0, s1, div0, ovf, special;
    logic [N_BITS-1:0]   mag0, mag1, special_res;
    logic [N_BITS:0]     mul_sum, div_shift, div_trial;
    logic [2*N_BITS-1:0] acc_step, prod_signed;
    logic [N_BITS-1:0]   quo, rem, calc_res;

    assign accept  = bus.in_valid & bus.in_ready & ~flush;
    assign is_div  = bus.op[2];
    assign s0      = bus.in0[N_BITS-1] & (bus.op == 3'b001 || bus.op == 3'b010 ||
                                          bus.op == 3'b100 || bus.op == 3'b110);
    assign s1      = bus.in1[N_BITS-1] & (bus.op == 3'b001 || bus.op == 3'b100 || bus.op == 3'b110);
    assign mag0    = s0 ? -bus.in0 : bus.in0;
    assign mag1    = s1 ? -bus.in1 : bus.in1;
    assign div0    = is_div & (bus.in1 == '0);
    assign ovf     = (bus.op == 3'b100 || bus.op == 3'b110) & (bus.in0 == MIN_NEG) & (bus.in1 == ALL_ONES);
    assign special = div0 | ovf;
    assign special_res = div0 ? (bus.op[1] ? bus.in0 : ALL_ONES) : (bus.op[1] ? '0 : bus.in0);

    // acc_q holds {high product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    assign mul_sum   = {1'b0, acc_q[2*N_BITS-1:N_BITS]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = acc_q[2*N_BITS-1:N_BITS-1];
    assign div_trial = div_shift - {1'b0, opnd_q};
    assign acc_step  = op_q[2] ? (div_trial[N_BITS] ? {div_shift[N_BITS-1:0], acc_q[N_BITS-2:0], 1'b0}
                                                    : {div_trial[N_BITS-1:0], acc_q[N_BITS-2:0], 1'b1})
                               : {mul_sum, acc_q[N_BITS-1:1]};

    assign prod_signed = neg_q ? -acc_step : acc_step;
    assign quo         = acc_step[N_BITS-1:0];
    assign rem         = acc_step[2*N_BITS-1:N_BITS];

    always_comb begin
        case (op_q)
            3'b000:                 calc_res = prod_signed[N_BITS-1:0];
            3'b001, 3'b010, 3'b011: calc_res = prod_signed[2*N_BITS-1:N_BITS];
            3'b100, 3'b101:         calc_res = neg_q ? -quo : quo;
            default:                calc_res = neg_q ? -rem : rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_comb begin
        cnt_d  = cnt_q;
        op_d   = op_q;
        neg_d  = neg_q;
        opnd_d = opnd_q;
        acc_d  = acc_q;
        out_d  = out_q;
        if (accept) begin
            op_d   = bus.op;
            neg_d  = (bus.op[2] & bus.op[1]) ? s0 : (s0 ^ s1);
            cnt_d  = CNT_W'(N_BITS - 1);
            opnd_d = is_div ? mag1 : mag0;
            acc_d  = is_div ? {{N_BITS{1'b0}}, mag0} : {{N_BITS{1'b0}}, mag1};
            if (special) out_d = special_res;
        end else if (state_q == CALC && !flush) begin
            acc_d = acc_step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) out_d = calc_res;
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.out       = out_q;
    end
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    localparam int N = 32;

    typedef struct {
        logic [N-1:0] val;
        int           cyc;
        int           lat;
    } exp_t;

    logic clk, rst_n, flush;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   rdy_force = 0;
    bit   rdy_val = 0;
    exp_t sb[$];

    muldiv_unit_if #(.N_BITS(N)) dut_if();

    muldiv_unit #(.N_BITS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (dut_if)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference semantics of RV32M written directly with 64-bit arithmetic.
    function automatic logic [N-1:0] ref_model(input logic [2:0] op, input logic [N-1:0] a,
                                               input logic [N-1:0] b);
        longint      sa = longint'($signed(a));
        longint      sb_ = longint'($signed(b));
        longint      ub = longint'({32'b0, b});
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ubb = {32'b0, b};
        logic [63:0] p;
        bit          ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = ua * ubb; return p[31:0]; end
            3'd1: begin p = sa * sb_; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ubb; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb_; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 0;
                p = sa % sb_; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return N + 1;
    endfunction

    initial begin
        dut_if.out_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            dut_if.out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency on rise of out_valid, stability while stalled, value on handshake.
    initial begin
        bit           prev_vld = 0;
        bit           prev_rdy = 0;
        logic [N-1:0] prev_out = '0;
        forever begin
            @(negedge clk);
            if (rst_n && dut_if.out_valid) begin
                if (sb.size() == 0) begin
                    if (!prev_vld) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_result: got out=%h with no request outstanding", dut_if.out);
                    end
                end else begin
                    if (!prev_vld) chk("latency", cyc - sb[0].cyc, sb[0].lat);
                    if (prev_vld && !prev_rdy) chk("stall_stable", dut_if.out, prev_out);
                    if (dut_if.out_ready) begin
                        chk("result", dut_if.out, sb[0].val);
                        void'(sb.pop_front());
                    end
                end
            end
            prev_vld = rst_n && dut_if.out_valid;
            prev_rdy = dut_if.out_ready;
            prev_out = dut_if.out;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] exp, input int lat, input bit push);
        int wait_n = 0;
        bit done = 0;
        @(posedge clk);
        #1;
        dut_if.in_valid = 1;
        dut_if.op       = op;
        dut_if.in0      = a;
        dut_if.in1      = b;
        while (!done) begin
            @(negedge clk);
            if (dut_if.in_ready) begin
                if (push) sb.push_back('{exp, cyc, lat});
                done = 1;
            end else if (++wait_n > 300) begin
                n_cmp++;
                n_err++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", wait_n);
                done = 1;
            end
        end
        @(posedge clk);
        #1;
        dut_if.in_valid = 0;
        dut_if.op       = 3'($urandom);
        dut_if.in0      = $urandom;
        dut_if.in1      = $urandom;
    endtask

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    logic [2:0]   d_op [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [N-1:0] d_a  [12] = '{32'h7, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [N-1:0] d_b  [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [N-1:0] d_e  [12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
    int           d_l  [12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};

    initial begin
        int hi;
        int wait_n;
        logic [2:0]   op;
        logic [N-1:0] a, b;
        rst_n           = 0;
        flush           = 0;
        dut_if.in_valid = 0;
        dut_if.op       = 0;
        dut_if.in0      = 0;
        dut_if.in1      = 0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 32'(dut_if.in_ready), 1);
        chk("reset_out_valid", 32'(dut_if.out_valid), 0);
        chk("reset_out", dut_if.out, 0);
        rst_n = 1;

        for (int i = 0; i < 12; i++) issue(d_op[i], d_a[i], d_b[i], d_e[i], d_l[i], 1);

        // Backpressure: hold the result for 10 cycles.
        wait_n = 0;
        while (sb.size() != 0 && wait_n < 300) begin
            @(negedge clk);
            wait_n++;
        end
        rdy_force = 1;
        rdy_val   = 0;
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1);
        wait_n = 0;
        do begin
            @(negedge clk);
            wait_n++;
        end while (!dut_if.out_valid && wait_n < 100);
        chk("bp_valid_seen", 32'(dut_if.out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 32'(dut_if.out_valid), 1);
            chk("bp_in_ready", 32'(dut_if.in_ready), 0);
            chk("bp_out", dut_if.out, 32'hFFFF_FFFE);
            @(negedge clk);
        end
        rdy_val = 1;
        repeat (2) @(negedge clk);
        chk("bp_in_ready_after", 32'(dut_if.in_ready), 1);
        chk("bp_out_valid_after", 32'(dut_if.out_valid), 0);
        rdy_force = 0;

        // Flush in CALC cycle 5.
        issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1 flush = 1;
        @(posedge clk);
        #1 flush = 0;
        @(negedge clk);
        chk("flush_in_ready", 32'(dut_if.in_ready), 1);
        hi = 0;
        repeat (40) begin
            @(negedge clk);
            if (dut_if.out_valid) hi++;
        end
        chk("flush_no_result", hi, 0);

        // Request offered in the same cycle as flush must be ignored.
        @(posedge clk);
        #1;
        flush = 1;
        dut_if.in_valid = 1;
        dut_if.op = 3'd5;
        dut_if.in0 = 32'd9;
        dut_if.in1 = 32'd0;
        @(posedge clk);
        #1;
        flush = 0;
        dut_if.in_valid = 0;
        hi = 0;
        repeat (5) begin
            @(negedge clk);
            if (dut_if.out_valid || !dut_if.in_ready) hi++;
        end
        chk("flush_blocks_accept", hi, 0);

        // Asynchronous reset in the middle of a divide.
        issue(3'd5, 32'hDEAD_BEEF, 32'd3, 0, 0, 0);
        repeat (10) @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("midrst_in_ready", 32'(dut_if.in_ready), 1);
        chk("midrst_out_valid", 32'(dut_if.out_valid), 0);
        chk("midrst_out", dut_if.out, 0);
        @(negedge clk);
        rst_n = 1;
        hi = 0;
        repeat (40) begin
            @(negedge clk);
            if (dut_if.out_valid) hi++;
        end
        chk("midrst_no_result", hi, 0);
        issue(3'd0, 32'd3, 32'd4, 32'd12, 33, 1);

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            issue(op, a, b, ref_model(op, a, b), ref_latency(op, a, b), 1);
        end

        wait_n = 0;
        while (sb.size() != 0 && wait_n < 500) begin
            @(negedge clk);
            wait_n++;
        end
        chk("drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
